// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl
//   Turns a single-cycle request from the CPU core into a timed pad-level bus
//   cycle: address/qualifier setup, an operation strobe whose length is either
//   a fixed number of wait states or set by an external asynchronous opack
//   handshake, and a hold phase that returns completion (and timeout error)
//   status to the core.
//
// Ports
//   wb_clk_i, reset_n      : clock (rising edge) and asynchronous active-low reset
//   core_req               : request strobe, only looked at while idle
//   core_we/mio/dc         : write select, memory/IO select, data/control select
//   core_addr, core_wdata  : request address and write data
//   core_rdata             : read data, valid while core_ack is high
//   core_ack, core_err     : one-cycle completion pulse and its timeout flag
//   busy                   : high whenever a bus cycle is in progress
//   adr, dbus_out, oeb     : pad address, pad write data and its active-low enable
//   dbus_in                : pad read data
//   m_io, d_c, rw          : pad cycle qualifiers (rw=1 is a write)
//   opreq, wrp             : operation request strobe and write pulse
//   opack                  : external acknowledge, asynchronous to wb_clk_i

module ext_bus_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int SETUP_CYC   = 1,
  parameter int WAIT_CYC    = 2,
  parameter int ACK_MODE    = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              wb_clk_i,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic              core_mio,
  input  logic              core_dc,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_err,
  output logic              busy,
  output logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] dbus_in,
  output logic [DATA_W-1:0] dbus_out,
  output logic              oeb,
  output logic              m_io,
  output logic              d_c,
  output logic              rw,
  output logic              opreq,
  output logic              wrp,
  input  logic              opack
);

  // One shared phase counter, wide enough for the longest phase.
  localparam int CNT_M1  = (SETUP_CYC > WAIT_CYC) ? SETUP_CYC : WAIT_CYC;
  localparam int CNT_MAX = (CNT_M1 > TIMEOUT_CYC) ? CNT_M1 : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_sync;

  logic                   strobe_done;
  logic                   timed_out;
  logic                   hold_done;

  logic [ADDR_W-1:0]      adr_d;
  logic [DATA_W-1:0]      dbus_out_d;
  logic [DATA_W-1:0]      core_rdata_d;
  logic                   oeb_d, m_io_d, d_c_d, rw_d, opreq_d, wrp_d;
  logic                   core_ack_d, core_err_d, busy_d;

  assign ack_sync = sync_q[SYNC_STAGES-1];

  // opack comes from outside the clock domain; a plain shift-register
  // synchroniser gives the FSM a clean copy SYNC_STAGES edges later.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], opack};
    end
  end

  // State, phase counter and every output are registered here; all
  // decisions are made in the combinational block below.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      adr        <= '0;
      dbus_out   <= '0;
      core_rdata <= '0;
      oeb        <= 1'b1;
      m_io       <= 1'b0;
      d_c        <= 1'b0;
      rw         <= 1'b0;
      opreq      <= 1'b0;
      wrp        <= 1'b0;
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr        <= adr_d;
      dbus_out   <= dbus_out_d;
      core_rdata <= core_rdata_d;
      oeb        <= oeb_d;
      m_io       <= m_io_d;
      d_c        <= d_c_d;
      rw         <= rw_d;
      opreq      <= opreq_d;
      wrp        <= wrp_d;
      core_ack   <= core_ack_d;
      core_err   <= core_err_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output logic. The registered rw doubles as the
  // latched write flag for the rest of the bus cycle. Outputs computed here
  // take effect on the edge that enters the corresponding state, so e.g.
  // opreq is already high in the first STROBE cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    adr_d        = adr;
    dbus_out_d   = dbus_out;
    core_rdata_d = core_rdata;
    oeb_d        = oeb;
    m_io_d       = m_io;
    d_c_d        = d_c;
    rw_d         = rw;
    opreq_d      = opreq;
    wrp_d        = 1'b0;
    core_ack_d   = 1'b0;
    core_err_d   = 1'b0;
    strobe_done  = 1'b0;
    timed_out    = 1'b0;
    hold_done    = 1'b0;

    // A real acknowledge wins over a timeout landing in the same cycle.
    if (ACK_MODE == 0) begin
      strobe_done = (cnt_q == WAIT_LAST);
      hold_done   = 1'b1;
    end else begin
      strobe_done = ack_sync || (cnt_q == TIMEOUT_LAST);
      timed_out   = !ack_sync && (cnt_q == TIMEOUT_LAST);
      hold_done   = !ack_sync || (cnt_q == TIMEOUT_LAST);
    end

    case (state_q)
      IDLE: begin
        if (core_req) begin
          adr_d  = core_addr;
          rw_d   = core_we;
          m_io_d = core_mio;
          d_c_d  = core_dc;
          if (core_we) begin
            dbus_out_d = core_wdata;
            oeb_d      = 1'b0;
          end
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          opreq_d = 1'b1;
          wrp_d   = rw;
          cnt_d   = '0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STROBE: begin
        if (strobe_done) begin
          opreq_d    = 1'b0;
          core_ack_d = 1'b1;
          core_err_d = timed_out;
          if (!rw) begin
            core_rdata_d = dbus_in;
          end
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        // Only the data enable and direction are released; adr and the
        // m_io/d_c qualifiers keep their last values.
        if (hold_done) begin
          oeb_d   = 1'b1;
          rw_d    = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// tb_ext_bus_ctrl
//   Self-checking bench for ext_bus_ctrl. Three instances share one clock and
//   reset: d0 with default parameters (fixed wait states), d1 with the opack
//   handshake enabled, and d2 with 16-bit buses and longer setup/wait.
//   Expected pad and core behaviour is computed from cycle offsets relative
//   to the accepting clock edge.
//
// Ports: none (top-level bench).

module tb_ext_bus_ctrl;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  logic        d0_req, d0_we, d0_mio, d0_dc, d0_ack, d0_err, d0_busy;
  logic        d0_oeb, d0_m_io, d0_d_c, d0_rw, d0_opreq, d0_wrp, d0_opack;
  logic [12:0] d0_addr, d0_adr;
  logic [7:0]  d0_wdata, d0_rdata, d0_dbus_in, d0_dbus_out;

  logic        d1_req, d1_we, d1_mio, d1_dc, d1_ack, d1_err, d1_busy;
  logic        d1_oeb, d1_m_io, d1_d_c, d1_rw, d1_opreq, d1_wrp, d1_opack;
  logic [12:0] d1_addr, d1_adr;
  logic [7:0]  d1_wdata, d1_rdata, d1_dbus_in, d1_dbus_out;

  logic        d2_req, d2_we, d2_mio, d2_dc, d2_ack, d2_err, d2_busy;
  logic        d2_oeb, d2_m_io, d2_d_c, d2_rw, d2_opreq, d2_wrp, d2_opack;
  logic [15:0] d2_addr, d2_adr;
  logic [15:0] d2_wdata, d2_rdata, d2_dbus_in, d2_dbus_out;

  ext_bus_ctrl dut0 (
    .wb_clk_i(clk), .reset_n(reset_n), .core_req(d0_req), .core_we(d0_we),
    .core_mio(d0_mio), .core_dc(d0_dc), .core_addr(d0_addr), .core_wdata(d0_wdata),
    .core_rdata(d0_rdata), .core_ack(d0_ack), .core_err(d0_err), .busy(d0_busy),
    .adr(d0_adr), .dbus_in(d0_dbus_in), .dbus_out(d0_dbus_out), .oeb(d0_oeb),
    .m_io(d0_m_io), .d_c(d0_d_c), .rw(d0_rw), .opreq(d0_opreq), .wrp(d0_wrp),
    .opack(d0_opack)
  );

  ext_bus_ctrl #(.ACK_MODE(1)) dut1 (
    .wb_clk_i(clk), .reset_n(reset_n), .core_req(d1_req), .core_we(d1_we),
    .core_mio(d1_mio), .core_dc(d1_dc), .core_addr(d1_addr), .core_wdata(d1_wdata),
    .core_rdata(d1_rdata), .core_ack(d1_ack), .core_err(d1_err), .busy(d1_busy),
    .adr(d1_adr), .dbus_in(d1_dbus_in), .dbus_out(d1_dbus_out), .oeb(d1_oeb),
    .m_io(d1_m_io), .d_c(d1_d_c), .rw(d1_rw), .opreq(d1_opreq), .wrp(d1_wrp),
    .opack(d1_opack)
  );

  ext_bus_ctrl #(.ADDR_W(16), .DATA_W(16), .SETUP_CYC(2), .WAIT_CYC(3)) dut2 (
    .wb_clk_i(clk), .reset_n(reset_n), .core_req(d2_req), .core_we(d2_we),
    .core_mio(d2_mio), .core_dc(d2_dc), .core_addr(d2_addr), .core_wdata(d2_wdata),
    .core_rdata(d2_rdata), .core_ack(d2_ack), .core_err(d2_err), .busy(d2_busy),
    .adr(d2_adr), .dbus_in(d2_dbus_in), .dbus_out(d2_dbus_out), .oeb(d2_oeb),
    .m_io(d2_m_io), .d_c(d2_d_c), .rw(d2_rw), .opreq(d2_opreq), .wrp(d2_wrp),
    .opack(d2_opack)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset values on every instance, both while reset is held and just after.
  task automatic test_reset;
    logic [37:0] got0, got1, want0;
    logic [56:0] got2, want2;
    reset_n = 1'b0;
    {d0_req, d0_we, d0_mio, d0_dc, d0_opack} = '0;
    {d1_req, d1_we, d1_mio, d1_dc, d1_opack} = '0;
    {d2_req, d2_we, d2_mio, d2_dc, d2_opack} = '0;
    d0_addr = '0; d0_wdata = '0; d0_dbus_in = '0;
    d1_addr = '0; d1_wdata = '0; d1_dbus_in = '0;
    d2_addr = '0; d2_wdata = '0; d2_dbus_in = '0;
    want0 = {13'h0, 8'h0, 8'h0, 9'b000001000};
    want2 = {16'h0, 16'h0, 16'h0, 9'b000001000};
    repeat (2) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      got0 = {d0_adr, d0_dbus_out, d0_rdata, d0_busy, d0_opreq, d0_wrp, d0_ack,
              d0_err, d0_oeb, d0_rw, d0_m_io, d0_d_c};
      got1 = {d1_adr, d1_dbus_out, d1_rdata, d1_busy, d1_opreq, d1_wrp, d1_ack,
              d1_err, d1_oeb, d1_rw, d1_m_io, d1_d_c};
      got2 = {d2_adr, d2_dbus_out, d2_rdata, d2_busy, d2_opreq, d2_wrp, d2_ack,
              d2_err, d2_oeb, d2_rw, d2_m_io, d2_d_c};
      vectors++;
      if (got0 !== want0) begin
        miscompares++;
        $display("[TB] FAIL reset_d0 pass %0d: got %h, want %h", pass, got0, want0);
      end
      vectors++;
      if (got1 !== want0) begin
        miscompares++;
        $display("[TB] FAIL reset_d1 pass %0d: got %h, want %h", pass, got1, want0);
      end
      vectors++;
      if (got2 !== want2) begin
        miscompares++;
        $display("[TB] FAIL reset_d2 pass %0d: got %h, want %h", pass, got2, want2);
      end
      reset_n = 1'b1;
      @(negedge clk);
    end
  endtask

  // Default-parameter write of 0xA5 to 0x1234, checked cycle by cycle.
  task automatic test_basic_write;
    logic [6:0] got, exp;
    logic       act;
    for (int cyc = 0; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        act = (cyc >= 1) && (cyc <= 4);
        exp = {act, (cyc == 2) || (cyc == 3), cyc == 2, cyc == 4, 1'b0, !act, act};
        got = {d0_busy, d0_opreq, d0_wrp, d0_ack, d0_err, d0_oeb, d0_rw};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL write_flags cyc %0d: got %b, want %b", cyc, got, exp);
        end
        vectors++;
        if (d0_adr !== 13'h1234) begin
          miscompares++;
          $display("[TB] FAIL write_adr cyc %0d: got %h, want 1234", cyc, d0_adr);
        end
        if (act) begin
          vectors++;
          if ({d0_dbus_out, d0_m_io, d0_d_c} !== {8'hA5, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL write_data cyc %0d: got %h/%b%b, want a5/10",
                     cyc, d0_dbus_out, d0_m_io, d0_d_c);
          end
        end
      end
      d0_req = (cyc == 0); d0_we = 1'b1; d0_addr = 13'h1234; d0_wdata = 8'hA5;
      d0_mio = 1'b1; d0_dc = 1'b0;
    end
  endtask

  // Random requests, including ones raised while busy, against a model that
  // tracks only "cycles since the accepting edge" and the accepted request.
  task automatic test_random_traffic;
    localparam int S = 1;
    localparam int W = 2;
    int          k;
    bit          seen;
    logic        t_we, t_mio, t_dc;
    logic [12:0] t_addr;
    logic [7:0]  t_wdata, t_rdata;
    logic [6:0]  got, exp;
    k = 0; seen = 1'b0;
    t_we = 1'b0; t_mio = 1'b0; t_dc = 1'b0;
    t_addr = '0; t_wdata = '0; t_rdata = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp = {k != 0, (k >= S + 1) && (k <= S + W), t_we && (k == S + 1),
             k == S + W + 1, 1'b0, !((k != 0) && t_we), (k != 0) && t_we};
      got = {d0_busy, d0_opreq, d0_wrp, d0_ack, d0_err, d0_oeb, d0_rw};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL rand_flags c %0d k %0d: got %b, want %b", c, k, got, exp);
      end
      if (seen) begin
        vectors++;
        if (d0_adr !== t_addr) begin
          miscompares++;
          $display("[TB] FAIL rand_adr c %0d: got %h, want %h", c, d0_adr, t_addr);
        end
      end
      if (k != 0) begin
        vectors++;
        if ({d0_m_io, d0_d_c} !== {t_mio, t_dc}) begin
          miscompares++;
          $display("[TB] FAIL rand_qual c %0d: got %b%b, want %b%b",
                   c, d0_m_io, d0_d_c, t_mio, t_dc);
        end
      end
      if ((k != 0) && t_we) begin
        vectors++;
        if (d0_dbus_out !== t_wdata) begin
          miscompares++;
          $display("[TB] FAIL rand_dbus_out c %0d: got %h, want %h", c, d0_dbus_out, t_wdata);
        end
      end
      if ((k == S + W + 1) && !t_we) begin
        vectors++;
        if (d0_rdata !== t_rdata) begin
          miscompares++;
          $display("[TB] FAIL rand_rdata c %0d: got %h, want %h", c, d0_rdata, t_rdata);
        end
      end
      d0_req     = ($urandom_range(0, 3) != 0);
      d0_we      = 1'($urandom);
      d0_mio     = 1'($urandom);
      d0_dc      = 1'($urandom);
      d0_addr    = 13'($urandom);
      d0_wdata   = 8'($urandom);
      d0_dbus_in = 8'($urandom);
      if ((k == S + W) && !t_we) t_rdata = d0_dbus_in;
      if (k == 0) begin
        if (d0_req) begin
          k = 1; seen = 1'b1;
          t_we = d0_we; t_mio = d0_mio; t_dc = d0_dc;
          t_addr = d0_addr; t_wdata = d0_wdata;
        end
      end else if (k == S + W + 1) begin
        k = 0;
      end else begin
        k++;
      end
    end
    d0_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // core_req held high: one acceptance every 5 cycles, nothing duplicated.
  task automatic test_back_to_back;
    logic [12:0] adr_exp;
    logic [1:0]  got, exp;
    logic        act;
    adr_exp = '0;
    for (int cyc = 0; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        act = (cyc <= 19) && ((cyc % 5) != 0);
        exp = {act, (cyc <= 19) && ((cyc % 5) == 4)};
        got = {d0_busy, d0_ack};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL b2b_busy_ack cyc %0d: got %b, want %b", cyc, got, exp);
        end
        if (act) begin
          vectors++;
          if (d0_adr !== adr_exp) begin
            miscompares++;
            $display("[TB] FAIL b2b_adr cyc %0d: got %h, want %h", cyc, d0_adr, adr_exp);
          end
        end
      end
      d0_req  = (cyc <= 19);
      d0_we   = 1'($urandom);
      d0_addr = 13'($urandom);
      if ((cyc % 5) == 0) adr_exp = d0_addr;
    end
    d0_req = 1'b0;
  endtask

  // Reset pulsed mid-STROBE: pads released at once, no ack, then a normal read.
  task automatic test_reset_mid_strobe;
    logic [6:0] got, exp;
    logic       act;
    d0_req = 1'b1; d0_we = 1'b1; d0_addr = 13'h0ABC; d0_wdata = 8'h5A;
    @(negedge clk);
    d0_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (d0_opreq !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_opreq: got %b, want 1", d0_opreq);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({d0_opreq, d0_oeb, d0_busy, d0_wrp, d0_rw} !== 5'b01000) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %b, want 01000",
               {d0_opreq, d0_oeb, d0_busy, d0_wrp, d0_rw});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      vectors++;
      if ({d0_ack, d0_busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL post_reset_idle cyc %0d: got %b, want 00", cyc, {d0_ack, d0_busy});
      end
    end
    for (int cyc = 0; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        act = (cyc >= 1) && (cyc <= 4);
        exp = {act, (cyc == 2) || (cyc == 3), 1'b0, cyc == 4, 1'b0, 1'b1, 1'b0};
        got = {d0_busy, d0_opreq, d0_wrp, d0_ack, d0_err, d0_oeb, d0_rw};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL recover_flags cyc %0d: got %b, want %b", cyc, got, exp);
        end
        if (cyc == 4) begin
          vectors++;
          if (d0_rdata !== 8'hC3) begin
            miscompares++;
            $display("[TB] FAIL recover_rdata: got %h, want c3", d0_rdata);
          end
        end
      end
      d0_req = (cyc == 0); d0_we = 1'b0; d0_addr = 13'h0321; d0_dbus_in = 8'hC3;
    end
  endtask

  // Handshake mode on d1. opack rises dly cycles after the first strobe cycle
  // and falls hdly cycles into HOLD; no_ack/no_drop exercise both timeouts.
  task automatic test_handshake(input int dly, input int hdly, input bit no_ack,
                                input bit no_drop, input bit we,
                                input logic [12:0] addr, input logic [7:0] data);
    int         f, r, e, d, last;
    logic [6:0] got, exp;
    logic       act;
    f = 2;
    if (no_ack) begin
      e = f + 14; r = 1000; d = 1000; last = e + 1;
    end else begin
      r = f + dly; e = r + 2;
      if (no_drop) begin
        d = 1000; last = e + 15;
      end else begin
        d = e + 1 + hdly; last = d + 2;
      end
    end
    for (int cyc = 0; cyc <= last + 2; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        act = (cyc >= 1) && (cyc <= last);
        exp = {act, (cyc >= f) && (cyc <= e), we && (cyc == f), cyc == e + 1,
               no_ack && (cyc == e + 1), !(act && we), act && we};
        got = {d1_busy, d1_opreq, d1_wrp, d1_ack, d1_err, d1_oeb, d1_rw};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL hs_flags dly %0d cyc %0d: got %b, want %b", dly, cyc, got, exp);
        end
        if (act) begin
          vectors++;
          if (d1_adr !== addr) begin
            miscompares++;
            $display("[TB] FAIL hs_adr cyc %0d: got %h, want %h", cyc, d1_adr, addr);
          end
        end
        if ((cyc == e + 1) && !we) begin
          vectors++;
          if (d1_rdata !== data) begin
            miscompares++;
            $display("[TB] FAIL hs_rdata cyc %0d: got %h, want %h", cyc, d1_rdata, data);
          end
        end
      end
      d1_req = (cyc == 0); d1_we = we; d1_addr = addr; d1_wdata = data;
      d1_dbus_in = data; d1_mio = 1'b1; d1_dc = 1'b0;
      d1_opack = (cyc >= r) && (cyc < d);
    end
    d1_opack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Wide instance d2: full 16-bit address/data, ack 6 cycles after request.
  task automatic test_wide(input bit we, input logic [15:0] addr, input logic [15:0] data);
    logic [6:0] got, exp;
    logic       act;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        act = (cyc >= 1) && (cyc <= 6);
        exp = {act, (cyc >= 3) && (cyc <= 5), we && (cyc == 3), cyc == 6, 1'b0,
               !(act && we), act && we};
        got = {d2_busy, d2_opreq, d2_wrp, d2_ack, d2_err, d2_oeb, d2_rw};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL wide_flags cyc %0d: got %b, want %b", cyc, got, exp);
        end
        vectors++;
        if (d2_adr !== addr) begin
          miscompares++;
          $display("[TB] FAIL wide_adr cyc %0d: got %h, want %h", cyc, d2_adr, addr);
        end
        if (act && we) begin
          vectors++;
          if (d2_dbus_out !== data) begin
            miscompares++;
            $display("[TB] FAIL wide_dbus_out cyc %0d: got %h, want %h", cyc, d2_dbus_out, data);
          end
        end
        if ((cyc == 6) && !we) begin
          vectors++;
          if (d2_rdata !== data) begin
            miscompares++;
            $display("[TB] FAIL wide_rdata: got %h, want %h", d2_rdata, data);
          end
        end
      end
      d2_req = (cyc == 0); d2_we = we; d2_addr = addr; d2_wdata = data;
      d2_dbus_in = data; d2_mio = 1'b0; d2_dc = 1'b1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic_write();
    test_random_traffic();
    test_back_to_back();
    test_reset_mid_strobe();
    test_handshake(5, 3, 1'b0, 1'b0, 1'b0, 13'h0010, 8'h3C);
    test_handshake(0, 0, 1'b1, 1'b0, 1'b0, 13'($urandom), 8'($urandom));
    test_handshake(2, 0, 1'b0, 1'b1, 1'b1, 13'($urandom), 8'($urandom));
    test_handshake(0, 0, 1'b0, 1'b0, 1'b1, 13'($urandom), 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      test_handshake(int'($urandom_range(0, 8)), int'($urandom_range(0, 6)), 1'b0, 1'b0,
                     1'($urandom), 13'($urandom), 8'($urandom));
    end
    test_wide(1'b1, 16'hFFFF, 16'hBEEF);
    test_wide(1'b0, 16'($urandom), 16'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ext_bus_ctrl.md
# ext_bus_ctrl

Parametrised external-bus controller between a CPU core's internal memory/IO request port and the user-project pads. It turns a single-cycle core request into a timed pad-level bus cycle with programmable address/data widths, setup and wait states, an optional asynchronous `opack` handshake, and a bus-timeout error. It is the successor to the fixed pad wiring of the current CPU wrapper and sits between the core and `io_in`/`io_out`/`io_oeb`.

## Interface
- `ADDR_W`, 13: address width, ≥ 1.
- `DATA_W`, 8: data bus width, ≥ 1.
- `SETUP_CYC`, 1: cycles of address/control setup before `opreq` rises, ≥ 1.
- `WAIT_CYC`, 2: `opreq` high time when `ACK_MODE`=0, ≥ 1.
- `ACK_MODE`, 0: 0 = fixed wait states; 1 = end strobe on synchronised `opack`.
- `SYNC_STAGES`, 2: flops in the `opack` synchroniser, ≥ 2.
- `TIMEOUT_CYC`, 15: maximum handshake wait cycles in `ACK_MODE`=1, ≥ 1.

Ports:
- `wb_clk_i` in 1: the single clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `core_req` in 1: request strobe, sampled in IDLE only.
- `core_we` in 1: 1 = write, 0 = read.
- `core_mio` in 1: memory (1) / IO (0) select, copied to `m_io`.
- `core_dc` in 1: data/control select for IO, copied to `d_c`.
- `core_addr` in `ADDR_W`: request address.
- `core_wdata` in `DATA_W`: write data.
- `core_rdata` out `DATA_W`: read data, valid while `core_ack`=1.
- `core_ack` out 1: one-cycle completion pulse.
- `core_err` out 1: qualifies `core_ack`; 1 = timed out.
- `busy` out 1: high in every state except IDLE.
- `adr` out `ADDR_W`: pad address.
- `dbus_in` in `DATA_W`: pad data in.
- `dbus_out` out `DATA_W`: pad data out.
- `oeb` out 1: data-pad output enable, active-low.
- `m_io`, `d_c`, `rw` out 1 each: pad cycle qualifiers (`rw`=1 means write).
- `opreq` out 1: operation request strobe.
- `wrp` out 1: write pulse.
- `opack` in 1: external acknowledge, asynchronous to `wb_clk_i`.

## Operation
- All outputs are registered. Reset values: `adr`=0, `dbus_out`=0, `oeb`=1, `m_io`=`d_c`=`rw`=`opreq`=`wrp`=0, `core_ack`=`core_err`=0, `core_rdata`=0, `busy`=0. The FSM resets to IDLE, the counters to 0 and the synchroniser to 0.
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE.
- IDLE: when `core_req`=1, latch address, data, `we`, `mio` and `dc`. Drive `adr`, `rw`, `m_io` and `d_c` from the latched values. For writes, drive `dbus_out` and set `oeb`=0. Go to SETUP.
- SETUP: hold for `SETUP_CYC` cycles, then go to STROBE.
- STROBE: `opreq`=1.
  - For writes, `wrp`=1 in the first STROBE cycle only.
  - `ACK_MODE`=0: STROBE lasts exactly `WAIT_CYC` cycles.
  - `ACK_MODE`=1: STROBE ends in the cycle the synchronised `opack` is 1 (minimum 1 cycle). If it has not ended after `TIMEOUT_CYC` cycles, it ends with an error.
  - For reads, `dbus_in` is captured into `core_rdata` on the final STROBE edge.
- HOLD: `opreq`=0. `adr`, qualifiers and `oeb` stay unchanged.
  - `core_ack`=1 in the first HOLD cycle only. `core_err`=1 in that cycle if the strobe timed out.
  - `ACK_MODE`=0: HOLD lasts 1 cycle.
  - `ACK_MODE`=1: HOLD waits for synchronised `opack`=0, for at most `TIMEOUT_CYC` cycles. It then goes to IDLE either way and does not report a second error.
- Leaving HOLD: `oeb`=1 and `rw`=0. `adr` keeps its last value.
- `core_req` is ignored outside IDLE; there is no queueing.
- Back-to-back: a request held high in the first IDLE cycle after HOLD is accepted.
- A read timeout still returns the `dbus_in` value sampled on the final edge; the core discards it because `core_err`=1.

## Timing
- Request-to-ack latency with `ACK_MODE`=0: `1+SETUP_CYC+WAIT_CYC` cycles (4 with defaults).
- `ACK_MODE`=1: `opack` reaches the FSM `SYNC_STAGES` cycles after its pad edge.
- Minimum cycle spacing between accepted requests: `SETUP_CYC+WAIT_CYC+2` with `ACK_MODE`=0.
- `adr` and the qualifiers are stable from the SETUP entry until leaving HOLD. `dbus_out` is driven (`oeb`=0) from the SETUP entry until leaving HOLD.
- `reset_n` low at any time, including mid-STROBE, forces the reset values immediately (asynchronously) and releases the pads (`oeb`=1). No `core_ack` is issued for the aborted cycle.

## Test plan
- Defaults, write 0xA5 to 0x1234: `adr`=0x1234, `oeb`=0 and `rw`=1 from cycle 1; `opreq` high in cycles 2–3; `wrp` high in cycle 2 only; `core_ack`=1 in cycle 4 with `core_err`=0.
- `ACK_MODE`=1, read 0x0010, `opack` raised 5 cycles after `opreq` and `dbus_in`=0x3C: `core_rdata`=0x3C and `core_ack`=1, `core_err`=0; the FSM returns to IDLE only after `opack` falls.
- `ACK_MODE`=1, `opack` never asserted: `opreq` stays high exactly 15 cycles; `core_ack`=1 and `core_err`=1; after HOLD, `busy`=0.
- `reset_n` pulsed low during STROBE of a write: in the same cycle `opreq`=0, `oeb`=1 and `busy`=0; no `core_ack`; the next request completes normally.
- `core_req` held high continuously: requests accepted every 5 cycles with defaults; requests during `busy` are not duplicated.
- `ADDR_W`=16, `DATA_W`=16, `SETUP_CYC`=2, `WAIT_CYC`=3: write 0xBEEF to 0xFFFF is driven full-width; `core_ack` arrives 6 cycles after the request.
